leo_key_scan: RTL and testbench

CPU-readable 4x4 matrix keypad scanner for the LEO board CPLD. It scans the keypad columns, debounces each key, and queues press/release events in a small FIFO. The CPU pops events over the EMI with a read strobe in the CS3 window ADDR[22:21]=2'b01, which is the read-side counterpart of the LED write window in the same decode space. KEY_INT tells the CPU that events are pending.

---
 rtl/leo_key_pkg.sv | 31 +++
 rtl/leo_key_fifo.sv | 59 +++++
 rtl/leo_key_scan.sv | 175 +++++++++++++++++
 tb/tb_leo_key_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/leo_key_pkg.sv
// Shared constants, event-word layout and scan state encoding for the LEO keypad scanner.
package leo_key_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    localparam int EV_VALID   = 7;
    localparam int EV_OVF     = 6;
    localparam int EV_REL     = 5;
    localparam int EV_CODE_HI = 3;
    localparam int EV_CODE_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        EVAL0,
        EVAL1,
        EVAL2,
        EVAL3
    } scan_state_t;

    function automatic logic [7:0] make_event(input logic rel, input logic [3:0] code);
        logic [7:0] w;
        w = '0;
        w[EV_VALID] = 1'b1;
        w[EV_REL] = rel;
        w[EV_CODE_HI:EV_CODE_LO] = code;
        return w;
    endfunction

endpackage

// File: rtl/leo_key_fifo.sv
// Small synchronous event FIFO; a pop frees room for a push in the same cycle.
// Exposes next-cycle head/empty so the owner can register its read data without extra lag.
module leo_key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         empty_nxt,
    output logic [W-1:0] head_nxt,
    output logic         push_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
    logic [AW:0]   count, count_nxt;
    logic          empty, full, do_pop, do_push;

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign push_drop  = push && !do_push;
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign empty_nxt  = (count_nxt == '0);

    always_comb begin
        head_nxt = mem[rd_ptr];
        if (empty || (count == (AW+1)'(1) && do_pop))
            head_nxt = din;
        else if (do_pop)
            head_nxt = mem[rd_ptr_inc];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr_inc;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/leo_key_scan.sv
// 4x4 keypad scanner with per-key debounce and a CPU-popped event FIFO on the CS3 read window.
// Build option: define KEY_RELEASE_EN to also queue key-release events.
module leo_key_scan
    import leo_key_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CS3_N,
    input  logic         BRD_N,
    input  logic [22:21] ADDR,
    input  logic [3:0]   KEY_ROW_N,
    output logic [3:0]   KEY_COL_N,
    output logic [7:0]   DATA_OUT,
    output logic         DATA_OE,
    output logic         KEY_INT
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NK = KEY_ROWS * KEY_COLS;

    // Bus drive follows the raw decode so the CPU sees data for the whole access.
    logic rd_act;
    assign rd_act  = !(CS3_N | BRD_N | ADDR[22] | !ADDR[21]);
    assign DATA_OE = rd_act;

    logic       rd_s1, rd_s2, rd_d, pop;
    logic [3:0] row_s1, row_s2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_s1  <= 1'b0;
            rd_s2  <= 1'b0;
            rd_d   <= 1'b0;
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            rd_s1  <= rd_act;
            rd_s2  <= rd_s1;
            rd_d   <= rd_s2;
            row_s1 <= KEY_ROW_N;
            row_s2 <= row_s1;
        end
    end

    // Pop only once the CPU has finished the read.
    assign pop = rd_d & ~rd_s2;

    scan_state_t   state;
    logic [1:0]    col, col_inc;
    logic [DW-1:0] div_cnt;
    logic [3:0]    rows_lat;

    assign col_inc = col + 2'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            col       <= 2'd0;
            div_cnt   <= '0;
            rows_lat  <= 4'h0;
            KEY_COL_N <= 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    col       <= 2'd0;
                    div_cnt   <= '0;
                    KEY_COL_N <= 4'b1110;
                    state     <= DRIVE;
                end
                DRIVE: begin
                    if (div_cnt == DW'(SCAN_DIV - 1)) begin
                        div_cnt  <= '0;
                        rows_lat <= ~row_s2;
                        state    <= EVAL0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                EVAL0: state <= EVAL1;
                EVAL1: state <= EVAL2;
                EVAL2: state <= EVAL3;
                EVAL3: begin
                    col       <= col_inc;
                    KEY_COL_N <= ~(4'b0001 << col_inc);
                    state     <= DRIVE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic                eval, sample, commit, push, push_drop;
    logic [1:0]          erow;
    logic [3:0]          key;
    logic [7:0]          push_word;
    logic [NK-1:0]       stable;
    logic [NK-1:0][2:0]  cnt;

    always_comb begin
        eval = 1'b1;
        erow = 2'd0;
        case (state)
            EVAL0:   erow = 2'd0;
            EVAL1:   erow = 2'd1;
            EVAL2:   erow = 2'd2;
            EVAL3:   erow = 2'd3;
            default: eval = 1'b0;
        endcase
        key    = {erow, col};
        sample = rows_lat[erow];
        commit = eval && (sample != stable[key]) && (cnt[key] == 3'(DEBOUNCE_SCANS - 1));
`ifdef KEY_RELEASE_EN
        push      = commit;
        push_word = make_event(!sample, key);
`else
        push      = commit && sample;
        push_word = make_event(1'b0, key);
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable <= '0;
            cnt    <= '0;
        end else if (eval) begin
            if (sample == stable[key]) begin
                cnt[key] <= 3'd0;
            end else if (commit) begin
                stable[key] <= sample;
                cnt[key]    <= 3'd0;
            end else begin
                cnt[key] <= cnt[key] + 3'd1;
            end
        end
    end

    logic       f_empty_nxt;
    logic [7:0] f_head_nxt;

    leo_key_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .din      (push_word),
        .pop      (pop),
        .empty_nxt(f_empty_nxt),
        .head_nxt (f_head_nxt),
        .push_drop(push_drop)
    );

    logic       ovf, ovf_nxt;
    logic [7:0] rd_word;

    always_comb begin
        ovf_nxt = pop ? 1'b0 : (ovf | push_drop);
        rd_word = f_empty_nxt ? 8'h00 : f_head_nxt;
        rd_word[EV_OVF] = ovf_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf      <= 1'b0;
            KEY_INT  <= 1'b0;
            DATA_OUT <= 8'h00;
        end else begin
            ovf      <= ovf_nxt;
            KEY_INT  <= !f_empty_nxt;
            DATA_OUT <= rd_word;
        end
    end

endmodule

// File: tb/tb_leo_key_scan.sv
// Scoreboard bench for leo_key_scan: keypad matrix model, queued expected events, CPU reads.
module tb_leo_key_scan;
    localparam int SD   = 8;
    localparam int DB   = 4;
    localparam int FD   = 4;
    localparam int SCAN = 4 * (SD + 4);

    logic         CLK = 1'b0;
    logic         RST, CS3_N, BRD_N;
    logic [22:21] ADDR;
    logic [3:0]   KEY_ROW_N, KEY_COL_N;
    logic [7:0]   DATA_OUT;
    logic         DATA_OE, KEY_INT;

    logic [15:0]  pressed;
    logic [7:0]   exp_q[$];
    logic         exp_ovf;
    int           total = 0;
    int           bad = 0;

    always #5 CLK = ~CLK;

    always_comb begin
        KEY_ROW_N = 4'hF;
        for (int r = 0; r < 4; r++)
            KEY_ROW_N[r] = ~|(pressed[r*4 +: 4] & ~KEY_COL_N);
    end

    leo_key_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(FD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CS3_N    (CS3_N),
        .BRD_N    (BRD_N),
        .ADDR     (ADDR),
        .KEY_ROW_N(KEY_ROW_N),
        .KEY_COL_N(KEY_COL_N),
        .DATA_OUT (DATA_OUT),
        .DATA_OE  (DATA_OE),
        .KEY_INT  (KEY_INT)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] w);
        if (exp_q.size() == FD) exp_ovf = 1'b1;
        else exp_q.push_back(w);
    endtask

    function automatic logic [7:0] model_pop();
        logic [7:0] w;
        w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        w[6] = exp_ovf;
        exp_ovf = 1'b0;
        return w;
    endfunction

    // Change one key and hold it long enough for the debounce to commit.
    task automatic set_key(input int k, input logic v);
        pressed[k] = v;
        if (v) model_push(8'(8'h80 | k));
`ifdef KEY_RELEASE_EN
        else model_push(8'(8'hA0 | k));
`endif
        repeat (5 * SCAN) @(negedge CLK);
    endtask

    task automatic cpu_read(input string tag);
        logic [7:0] e;
        CS3_N = 1'b0; BRD_N = 1'b0; ADDR = 2'b01;
        repeat (4) @(negedge CLK);
        chk({tag, "_oe"}, {7'h0, DATA_OE}, 8'h01);
        e = model_pop();
        chk(tag, DATA_OUT, e);
        CS3_N = 1'b1; BRD_N = 1'b1;
        repeat (6) @(negedge CLK);
        chk({tag, "_int"}, {7'h0, KEY_INT}, {7'h0, exp_q.size() != 0});
    endtask

    initial begin
        logic [3:0] ec, prev;
        logic [7:0] e;
        bit found;
        int p;
        RST = 1'b1; CS3_N = 1'b1; BRD_N = 1'b1; ADDR = 2'b00;
        pressed = '0; exp_ovf = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_col", {4'h0, KEY_COL_N}, 8'h0F);
        chk("rst_data", DATA_OUT, 8'h00);
        chk("rst_int", {7'h0, KEY_INT}, 8'h00);
        chk("idle_oe", {7'h0, DATA_OE}, 8'h00);
        RST = 1'b0;

        // column walk over three idle scans
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            if (KEY_COL_N != 4'hF) found = 1;
        end
        chk("col_start", {7'h0, found}, 8'h01);
        for (int k = 0; k < 12; k++) begin
            ec = ~(4'b0001 << (k % 4));
            chk("col_walk", {4'h0, KEY_COL_N}, {4'h0, ec});
            repeat (SCAN / 4) @(negedge CLK);
        end
        chk("idle_int", {7'h0, KEY_INT}, 8'h00);
        cpu_read("idle_rd");

        // single press row2/col1
        set_key(9, 1'b1);
        chk("p9_int", {7'h0, KEY_INT}, 8'h01);
        cpu_read("p9_rd");
        cpu_read("p9_rd2");
        set_key(9, 1'b0);
        cpu_read("r9_rd");

        // bounce row0/col0 every scan
        for (int i = 0; i < 10; i++) begin
            pressed[0] = ~pressed[0];
            repeat (SCAN) @(negedge CLK);
        end
        repeat (2 * SCAN) @(negedge CLK);
        chk("bounce_int", {7'h0, KEY_INT}, 8'h00);
        cpu_read("bounce_rd");

        // press and release row3/col3
        set_key(15, 1'b1);
        set_key(15, 1'b0);
        cpu_read("k15_rd1");
        cpu_read("k15_rd2");
        cpu_read("k15_rd3");

        // six presses overflow a four-entry queue
        for (int k = 1; k <= 6; k++) set_key(k, 1'b1);
        for (int i = 0; i < 5; i++) cpu_read("ovf_rd");
        for (int k = 1; k <= 6; k++) set_key(k, 1'b0);
        for (int i = 0; i < 5; i++) cpu_read("ovf_rel_rd");

        // full queue with pop and push landing in the same cycle
        set_key(10, 1'b1);
        set_key(11, 1'b1);
        set_key(12, 1'b1);
        set_key(13, 1'b1);
        found = 0;
        prev = KEY_COL_N;
        for (int i = 0; i < 4 * SCAN && !found; i++) begin
            @(negedge CLK);
            if (KEY_COL_N == 4'b0111 && prev != 4'b0111) found = 1;
            else prev = KEY_COL_N;
        end
        chk("col3_wait", {7'h0, found}, 8'h01);
        // key 7 (row1/col3) commits in EVAL1 of the fourth scan of this column
        pressed[7] = 1'b1;
        p = 3 * SCAN + SD + 1;
        repeat (p - 8) @(negedge CLK);
        CS3_N = 1'b0; BRD_N = 1'b0; ADDR = 2'b01;
        repeat (4) @(negedge CLK);
        e = model_pop();
        chk("same_rd", DATA_OUT, e);
        repeat (2) @(negedge CLK);
        CS3_N = 1'b1; BRD_N = 1'b1;
        model_push(8'h87);
        repeat (8) @(negedge CLK);
        for (int i = 0; i < 5; i++) cpu_read("same_drain");

        // reset in the middle of a read
        CS3_N = 1'b0; BRD_N = 1'b0; ADDR = 2'b01;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rrd_data", DATA_OUT, 8'h00);
        chk("rrd_col", {4'h0, KEY_COL_N}, 8'h0F);
        chk("rrd_int", {7'h0, KEY_INT}, 8'h00);
        RST = 1'b0;
        CS3_N = 1'b1; BRD_N = 1'b1;
        repeat (4) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
